// File: rtl/tm_inference_sequencer.sv
// Sequencer for the 3-class, 12-clause Tsetlin Machine inference datapath.
// Holds the clause exclude words, feeds samples to the datapath and returns the settled class.
module tm_inference_sequencer #(
   parameter int unsigned N_FEAT   = 9,
   parameter int unsigned N_LIT    = 18,
   parameter int unsigned N_CLAUSE = 12,
   parameter int unsigned CLS_W    = 2,
   parameter int unsigned SETTLE   = 2,
   parameter int unsigned CNT_W    = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      cfg_wr_en,
   input  logic [3:0]                cfg_addr,
   input  logic [N_LIT-1:0]          cfg_data,
   input  logic                      cfg_done,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [N_FEAT-1:0]         in_features,
   output logic [N_FEAT-1:0]         dp_features,
   output logic [N_CLAUSE*N_LIT-1:0] dp_exclude,
   input  logic [CLS_W-1:0]          dp_class,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [CLS_W-1:0]          out_class,
   output logic                      busy,
   output logic                      cfg_err,
   output logic [CNT_W-1:0]          infer_count
);

   localparam int unsigned ADDR_W = 4;
   localparam int unsigned SET_W  = 4;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_CLAUSE - 1);
   localparam logic [SET_W-1:0]  SETTLE_LD = SET_W'(SETTLE);

   typedef enum logic [1:0] {
      ST_CONFIG = 2'd0,
      ST_IDLE   = 2'd1,
      ST_EVAL   = 2'd2,
      ST_HOLD   = 2'd3
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [SET_W-1:0] settle_cnt;
   logic             addr_ok_c;
   logic             write_c;
   logic             accept_c;
   logic             capture_c;
   logic             complete_c;
   logic             err_c;

   assign addr_ok_c = (cfg_addr <= LAST_ADDR);

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= ST_CONFIG;
      else     state <= state_next;
   end

   // Next-state and per-cycle action decode
   always_comb begin
      state_next = state;
      write_c    = 1'b0;
      accept_c   = 1'b0;
      capture_c  = 1'b0;
      complete_c = 1'b0;
      err_c      = 1'b0;
      case (state)
         ST_CONFIG: begin
            if (cfg_wr_en) begin
               write_c = addr_ok_c;
               err_c   = !addr_ok_c;
            end
            if (cfg_done) state_next = ST_IDLE;
         end
         ST_IDLE: begin
            // A config write wins over a pending sample and reopens configuration.
            if (cfg_wr_en) begin
               write_c    = addr_ok_c;
               err_c      = !addr_ok_c;
               state_next = ST_CONFIG;
            end else if (in_valid) begin
               accept_c   = 1'b1;
               state_next = ST_EVAL;
            end
         end
         ST_EVAL: begin
            err_c = cfg_wr_en | cfg_done;
            if (settle_cnt == SET_W'(1)) begin
               capture_c  = 1'b1;
               state_next = ST_HOLD;
            end
         end
         ST_HOLD: begin
            err_c = cfg_wr_en | cfg_done;
            if (out_ready) begin
               complete_c = 1'b1;
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_CONFIG;
      endcase
   end

   // Registered datapath, handshake flags and status
   always_ff @(posedge clk) begin
      if (rst) begin
         dp_exclude  <= '0;
         dp_features <= '0;
         out_class   <= '0;
         infer_count <= '0;
         cfg_err     <= 1'b0;
         settle_cnt  <= '0;
         in_ready    <= 1'b0;
         out_valid   <= 1'b0;
         busy        <= 1'b0;
      end else begin
         in_ready  <= (state_next == ST_IDLE);
         out_valid <= (state_next == ST_HOLD);
         busy      <= (state_next == ST_EVAL) || (state_next == ST_HOLD);
         if (write_c) begin
            for (int unsigned i = 0; i < N_CLAUSE; i++) begin
               if (cfg_addr == ADDR_W'(i)) dp_exclude[i*N_LIT +: N_LIT] <= cfg_data;
            end
         end
         if (accept_c) begin
            dp_features <= in_features;
            settle_cnt  <= SETTLE_LD;
         end else if (state == ST_EVAL) begin
            settle_cnt <= settle_cnt - SET_W'(1);
         end
         if (capture_c) out_class <= dp_class;
         if (err_c)     cfg_err   <= 1'b1;
         infer_count <= infer_count + CNT_W'(complete_c);
      end
   end

endmodule

// File: tb/tb_tm_inference_sequencer.sv
// Self-checking bench for tm_inference_sequencer: mode-level reference model compared
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_tm_inference_sequencer;

   localparam int unsigned N_FEAT   = 9;
   localparam int unsigned N_LIT    = 18;
   localparam int unsigned N_CLAUSE = 12;
   localparam int unsigned CLS_W    = 2;
   localparam int unsigned SETTLE   = 2;
   localparam int unsigned CNT_W    = 16;
   localparam int unsigned XW       = N_CLAUSE * N_LIT;

   localparam int MD_CFG  = 0;
   localparam int MD_IDLE = 1;
   localparam int MD_BUSY = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic              cfg_wr_en;
   logic [3:0]        cfg_addr;
   logic [N_LIT-1:0]  cfg_data;
   logic              cfg_done;
   logic              in_valid;
   logic              in_ready;
   logic [N_FEAT-1:0] in_features;
   logic [N_FEAT-1:0] dp_features;
   logic [XW-1:0]     dp_exclude;
   logic [CLS_W-1:0]  dp_class;
   logic              out_valid;
   logic              out_ready;
   logic [CLS_W-1:0]  out_class;
   logic              busy;
   logic              cfg_err;
   logic [CNT_W-1:0]  infer_count;

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   // Reference model state
   int                m_mode;
   int                m_age;
   logic [N_LIT-1:0]  m_excl [N_CLAUSE];
   logic [N_FEAT-1:0] m_feat;
   logic [CLS_W-1:0]  m_class;
   logic [CNT_W-1:0]  m_count;
   logic              m_err;

   tm_inference_sequencer #(
      .N_FEAT(N_FEAT), .N_LIT(N_LIT), .N_CLAUSE(N_CLAUSE),
      .CLS_W(CLS_W), .SETTLE(SETTLE), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst),
      .cfg_wr_en(cfg_wr_en), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_done(cfg_done),
      .in_valid(in_valid), .in_ready(in_ready), .in_features(in_features),
      .dp_features(dp_features), .dp_exclude(dp_exclude), .dp_class(dp_class),
      .out_valid(out_valid), .out_ready(out_ready), .out_class(out_class),
      .busy(busy), .cfg_err(cfg_err), .infer_count(infer_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic chk_wide(input string nm, input logic [XW-1:0] act, input logic [XW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic model_write();
      if (cfg_addr < 4'(N_CLAUSE)) m_excl[cfg_addr] = cfg_data;
      else                         m_err = 1'b1;
   endtask

   // Model: a result appears SETTLE edges after acceptance and leaves on handshake.
   always @(posedge clk) begin
      if (rst) begin
         m_mode  = MD_CFG;
         m_age   = 0;
         m_feat  = '0;
         m_class = '0;
         m_count = '0;
         m_err   = 1'b0;
         for (int i = 0; i < N_CLAUSE; i++) m_excl[i] = '0;
      end else begin
         case (m_mode)
            MD_CFG: begin
               if (cfg_wr_en) model_write();
               if (cfg_done) m_mode = MD_IDLE;
            end
            MD_IDLE: begin
               if (cfg_wr_en) begin
                  model_write();
                  m_mode = MD_CFG;
               end else if (in_valid) begin
                  m_feat = in_features;
                  m_age  = 0;
                  m_mode = MD_BUSY;
               end
            end
            default: begin
               if (cfg_wr_en || cfg_done) m_err = 1'b1;
               if (m_age < int'(SETTLE)) begin
                  m_age++;
                  if (m_age == int'(SETTLE)) m_class = dp_class;
               end else if (out_ready) begin
                  m_count = m_count + 1'b1;
                  m_mode  = MD_IDLE;
               end
            end
         endcase
      end
   end

   // Every-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      if (chk_en) begin
         logic [XW-1:0] exp_x;
         for (int i = 0; i < N_CLAUSE; i++) exp_x[i*N_LIT +: N_LIT] = m_excl[i];
         chk("cyc in_ready", 64'(in_ready), 64'(m_mode == MD_IDLE));
         chk("cyc busy", 64'(busy), 64'(m_mode == MD_BUSY));
         chk("cyc out_valid", 64'(out_valid), 64'(m_mode == MD_BUSY && m_age >= int'(SETTLE)));
         chk("cyc dp_features", 64'(dp_features), 64'(m_feat));
         chk("cyc out_class", 64'(out_class), 64'(m_class));
         chk("cyc cfg_err", 64'(cfg_err), 64'(m_err));
         chk("cyc infer_count", 64'(infer_count), 64'(m_count));
         chk_wide("cyc dp_exclude", dp_exclude, exp_x);
      end
   end

   task automatic wait_valid(input string nm);
      int n = 0;
      while (!out_valid && n < 20) begin
         step();
         n++;
      end
      if (!out_valid) chk(nm, 64'(out_valid), 64'd1);
   endtask

   initial begin
      int ht [3];
      int hs;
      logic [N_LIT-1:0] exp_w;

      rst = 1'b1; cfg_wr_en = 1'b0; cfg_addr = '0; cfg_data = '0; cfg_done = 1'b0;
      in_valid = 1'b0; in_features = '0; dp_class = '0; out_ready = 1'b0;

      // Reset state
      step(); step();
      rst = 1'b0;
      chk("rst in_ready", 64'(in_ready), 64'd0);
      chk("rst out_valid", 64'(out_valid), 64'd0);
      chk("rst busy", 64'(busy), 64'd0);
      chk("rst infer_count", 64'(infer_count), 64'd0);
      chk("rst cfg_err", 64'(cfg_err), 64'd0);
      chk_wide("rst dp_exclude", dp_exclude, '0);
      chk_en = 1'b1;

      // Configuration: last write coincides with cfg_done
      for (int i = 0; i < int'(N_CLAUSE); i++) begin
         cfg_wr_en = 1'b1;
         cfg_addr  = 4'(i);
         cfg_data  = 18'h3FFFF ^ 18'(i);
         cfg_done  = (i == int'(N_CLAUSE) - 1);
         step();
      end
      cfg_wr_en = 1'b0; cfg_done = 1'b0;
      chk("cfg in_ready", 64'(in_ready), 64'd1);
      for (int i = 0; i < int'(N_CLAUSE); i++) begin
         exp_w = 18'h3FFFF ^ 18'(i);
         chk("cfg slice", 64'(dp_exclude[i*N_LIT +: N_LIT]), 64'(exp_w));
      end

      // Single inference: latency SETTLE edges, result held under backpressure
      dp_class = 2'b10; in_features = 9'h1A5; in_valid = 1'b1;
      step();
      in_valid = 1'b0; in_features = 9'h000;
      chk("t3 dp_features", 64'(dp_features), 64'h1A5);
      chk("t3 valid k", 64'(out_valid), 64'd0);
      step();
      chk("t3 valid k+1", 64'(out_valid), 64'd0);
      step();
      chk("t3 valid k+2", 64'(out_valid), 64'd1);
      chk("t3 out_class", 64'(out_class), 64'h2);
      dp_class = 2'b01;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("t3 hold valid", 64'(out_valid), 64'd1);
         chk("t3 hold class", 64'(out_class), 64'h2);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("t3 count", 64'(infer_count), 64'd1);

      // Back-to-back stream: one result per SETTLE+2 edges, no same-cycle accept
      in_valid = 1'b1; out_ready = 1'b1; hs = 0;
      for (int c = 0; c < 40 && hs < 3; c++) begin
         in_features = 9'(c * 37 + 5);
         dp_class    = 2'(c);
         chk("t4 ready&valid", 64'(in_ready & out_valid), 64'd0);
         if (out_valid && out_ready) begin
            ht[hs] = c;
            hs++;
         end
         step();
      end
      in_valid = 1'b0; out_ready = 1'b0;
      chk("t4 handshakes", 64'(hs), 64'd3);
      if (hs == 3) begin
         chk("t4 gap1", 64'(ht[1] - ht[0]), 64'(SETTLE + 2));
         chk("t4 gap2", 64'(ht[2] - ht[1]), 64'(SETTLE + 2));
      end
      chk("t4 count", 64'(infer_count), 64'd4);

      // Config errors: bad address in CONFIG, write attempt while evaluating
      cfg_wr_en = 1'b1; cfg_addr = 4'd0; cfg_data = 18'h3FFFF;
      step();
      chk("t5 back to config", 64'(in_ready), 64'd0);
      cfg_addr = 4'd13; cfg_data = 18'h00000;
      step();
      cfg_wr_en = 1'b0;
      chk("t5 cfg_err", 64'(cfg_err), 64'd1);
      for (int i = 0; i < int'(N_CLAUSE); i++) begin
         exp_w = 18'h3FFFF ^ 18'(i);
         chk("t5 slice", 64'(dp_exclude[i*N_LIT +: N_LIT]), 64'(exp_w));
      end
      cfg_done = 1'b1;
      step();
      cfg_done = 1'b0;
      dp_class = 2'b01; in_features = 9'h0F3; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      cfg_wr_en = 1'b1; cfg_addr = 4'd0; cfg_data = 18'h00000;
      step();
      cfg_wr_en = 1'b0;
      chk("t5 slice0 kept", 64'(dp_exclude[N_LIT-1:0]), 64'h3FFFF);
      chk("t5 busy", 64'(busy), 64'd1);
      wait_valid("t5 valid timeout");
      chk("t5 out_class", 64'(out_class), 64'h1);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("t5 count", 64'(infer_count), 64'd5);
      chk("t5 cfg_err sticky", 64'(cfg_err), 64'd1);

      // Reset in HOLD discards the result and clears everything
      in_valid = 1'b1; in_features = 9'h155;
      step();
      in_valid = 1'b0;
      wait_valid("t6 valid timeout");
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("t6 out_valid", 64'(out_valid), 64'd0);
      chk("t6 in_ready", 64'(in_ready), 64'd0);
      chk("t6 busy", 64'(busy), 64'd0);
      chk("t6 infer_count", 64'(infer_count), 64'd0);
      chk("t6 cfg_err", 64'(cfg_err), 64'd0);
      chk_wide("t6 dp_exclude", dp_exclude, '0);

      // Reconfigure, then counter wrap from all-ones
      for (int i = 0; i < int'(N_CLAUSE); i++) begin
         cfg_wr_en = 1'b1; cfg_addr = 4'(i); cfg_data = 18'(i * 4099 + 1);
         step();
      end
      cfg_wr_en = 1'b0; cfg_done = 1'b1;
      step();
      cfg_done = 1'b0;
      force dut.infer_count = 16'hFFFF;
      m_count = 16'hFFFF;
      step();
      release dut.infer_count;
      step();
      chk("t6 preset count", 64'(infer_count), 64'hFFFF);
      dp_class = 2'b11; in_features = 9'h0AA; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      wait_valid("t6b valid timeout");
      chk("t6 out_class", 64'(out_class), 64'h3);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("t6 wrap", 64'(infer_count), 64'd0);
      step(); step();

      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
